mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 94 +++++++++
 tb/tb_mult_div_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MIPS MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO path
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rsData,
  input  logic [WIDTH-1:0] rtData,
  input  logic             hiWriteEn,
  input  logic             loWriteEn,
  input  logic [WIDTH-1:0] writeData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FINISH = 2'd2;
  logic [1:0] state;
  logic [CNT_W-1:0] counter;
  logic isDiv, divZero, negQ, negR;
  logic [WIDTH-1:0] operandB, rsRaw;
  logic [2*WIDTH-1:0] work;
  logic aNeg, bNeg;
  logic [WIDTH-1:0] aMag, bMag;
  logic [WIDTH:0] addSum, remShift, diff;
  logic [2*WIDTH-1:0] mulNext, divNext, prodFix;
  logic [WIDTH-1:0] quot, rem;
  assign busy = state != IDLE;
  always_comb begin
    aNeg = op[0] & rsData[WIDTH-1];
    bNeg = op[0] & rtData[WIDTH-1];
    aMag = aNeg ? -rsData : rsData;
    bMag = bNeg ? -rtData : rtData;
    // work holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
    addSum = work[0] ? {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, operandB} : {1'b0, work[2*WIDTH-1:WIDTH]};
    mulNext = {addSum, work[WIDTH-1:1]};
    remShift = work[2*WIDTH-1:WIDTH-1];
    diff = remShift - {1'b0, operandB};
    divNext = diff[WIDTH] ? {remShift[WIDTH-1:0], work[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
    prodFix = negQ ? -work : work;
    quot = negQ ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    rem = negR ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      counter <= '0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      isDiv <= 1'b0;
      divZero <= 1'b0;
      negQ <= 1'b0;
      negR <= 1'b0;
      operandB <= '0;
      rsRaw <= '0;
      work <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hiWriteEn) hi <= writeData;
          if (loWriteEn) lo <= writeData;
          if (start) begin
            state <= CALC;
            counter <= '0;
            isDiv <= op[1];
            divZero <= op[1] & (rtData == '0);
            negQ <= aNeg ^ bNeg;
            negR <= aNeg;
            operandB <= bMag;
            rsRaw <= rsData;
            work <= {{WIDTH{1'b0}}, aMag};
          end
        end
        CALC: begin
          work <= isDiv ? divNext : mulNext;
          counter <= counter + 1'b1;
          if (counter == CNT_W'(WIDTH - 1)) state <= FINISH;
        end
        FINISH: begin
          hi <= !isDiv ? prodFix[2*WIDTH-1:WIDTH] : divZero ? rsRaw : rem;
          lo <= !isDiv ? prodFix[WIDTH-1:0] : divZero ? {WIDTH{1'b1}} : quot;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench; stimulus pushes expected HI/LO and done cycle, monitor checks on done
module tb_mult_div_unit;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, hiWriteEn = 1'b0, loWriteEn = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] rsData = '0, rtData = '0, writeData = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int vectors = 0, miscompares = 0, cyc = 0, doneCount = 0;
  typedef struct { logic [63:0] res; int cyc; } exp_t;
  typedef struct { logic [1:0] op; logic [31:0] a, b, eHi, eLo; } vec_t;
  exp_t sb[$];
  vec_t vecs[$];

  mult_div_unit dut (.clk(clk), .reset(reset), .start(start), .op(op), .rsData(rsData), .rtData(rtData),
    .hiWriteEn(hiWriteEn), .loWriteEn(loWriteEn), .writeData(writeData), .busy(busy), .done(done), .hi(hi), .lo(lo));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (done) begin
      doneCount++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done (cycle %0d)", hi, lo, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {hi, lo}, e.res);
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] eHi, input logic [31:0] eLo);
    start = 1'b1; op = o; rsData = a; rtData = b;
    sb.push_back('{{eHi, eLo}, cyc + 34});
    @(negedge clk);
    start = 1'b0; rsData = '0; rtData = '0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    vecs.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1});
    vecs.push_back('{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{2'b01, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001});
    vecs.push_back('{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780});
    vecs.push_back('{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vecs.push_back('{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF});
    vecs.push_back('{2'b11, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF});
    vecs.push_back('{2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF});

    repeat (3) @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'h0);
    chk("reset_busy_done", {62'h0, busy, done}, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // MULTU 6*7 with an ignored DIVU start and ignored MTLO while busy
    issue(2'b00, 32'd6, 32'd7, 32'h0, 32'd42);
    repeat (8) @(negedge clk);
    start = 1'b1; op = 2'b10; rsData = 32'd9; rtData = 32'd3;
    @(negedge clk);
    start = 1'b0; loWriteEn = 1'b1; writeData = 32'h1234;
    @(negedge clk);
    loWriteEn = 1'b0;
    chk("busy_mid", {63'h0, busy}, 64'h1);
    chk("mtlo_busy_ignored", {32'h0, lo}, 64'h0);
    waitDrain();
    chk("idle_busy", {63'h0, busy}, 64'h0);

    loWriteEn = 1'b1; writeData = 32'h1234;
    @(negedge clk);
    loWriteEn = 1'b0;
    chk("mtlo_idle", {hi, lo}, {32'h0, 32'h1234});
    hiWriteEn = 1'b1; loWriteEn = 1'b1; writeData = 32'hCAFEF00D;
    @(negedge clk);
    hiWriteEn = 1'b0; loWriteEn = 1'b0;
    chk("mthi_mtlo_both", {hi, lo}, {32'hCAFEF00D, 32'hCAFEF00D});

    // MTHI on the start edge lands first, then the result overwrites it
    hiWriteEn = 1'b1; writeData = 32'h0000AAAA;
    issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
    hiWriteEn = 1'b0;
    chk("mthi_with_start", {32'h0, hi}, {32'h0, 32'h0000AAAA});
    waitDrain();

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eHi, vecs[i].eLo);
      waitDrain();
    end

    // back-to-back: second start held during the done cycle
    issue(2'b10, 32'd1000, 32'd7, 32'd6, 32'd142);
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
    waitDrain();

    // reset mid-operation aborts with no done
    start = 1'b1; op = 2'b00; rsData = 32'd3; rtData = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("busy_before_abort", {63'h0, busy}, 64'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_hilo", {hi, lo}, 64'h0);
    chk("abort_busy_done", {62'h0, busy, done}, 64'h0);
    begin
      int dc;
      dc = doneCount;
      repeat (40) @(negedge clk);
      chk("abort_no_done", 64'(doneCount - dc), 64'h0);
    end
    chk("final_idle", {63'h0, busy}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
